// File: rtl/dual_port_mem_responder.sv
// Dual-port word memory responder: port 0 read-only, port 1 read/write with byte strobes.
// One-cycle registered reads, write-first collisions, optional zero-fill sweep after reset.
module dual_port_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   port0_addr,
  input  logic                    port0_read_en,
  output logic [DATA_WIDTH-1:0]   port0_rdata,
  output logic                    port0_rvalid,
  input  logic [ADDR_WIDTH-1:0]   port1_addr,
  input  logic [DATA_WIDTH-1:0]   port1_wdata,
  input  logic                    port1_write_en,
  input  logic [DATA_WIDTH/8-1:0] port1_strobe,
  input  logic                    port1_read_en,
  output logic [DATA_WIDTH-1:0]   port1_rdata,
  output logic                    port1_rvalid,
  output logic                    ready
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_LANES = DATA_WIDTH / 8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  accept;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] port0_word;
  logic [DATA_WIDTH-1:0] port1_word;

  assign accept = (state == ST_RUN) && ready;

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      byte_mask[8*i +: 8] = {8{port1_strobe[i]}};
    end
  end

  // Write-first: any read hitting the port 1 write address sees the merged word.
  assign merged_word = (mem[port1_addr] & ~byte_mask) | (port1_wdata & byte_mask);
  assign port0_word  = (port1_write_en && (port0_addr == port1_addr)) ? merged_word
                                                                      : mem[port0_addr];
  assign port1_word  = port1_write_en ? merged_word : mem[port1_addr];

  // Storage itself is never reset; the empty reset branch only stops writes while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[init_addr] <= '0;
      end else if (accept && port1_write_en) begin
        mem[port1_addr] <= merged_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= INIT_CLEAR ? ST_INIT : ST_RUN;
      init_addr    <= '0;
      ready        <= 1'b0;
      port0_rdata  <= '0;
      port0_rvalid <= 1'b0;
      port1_rdata  <= '0;
      port1_rvalid <= 1'b0;
    end else begin
      port0_rvalid <= 1'b0;
      port1_rvalid <= 1'b0;
      if (state == ST_INIT) begin
        init_addr <= init_addr + ADDR_WIDTH'(1);
        if (&init_addr) begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
      end else if (!ready) begin
        // No sweep: the first edge after reset only raises ready.
        ready <= 1'b1;
      end else begin
        if (port0_read_en) begin
          port0_rdata  <= port0_word;
          port0_rvalid <= 1'b1;
        end
        if (port1_read_en) begin
          port1_rdata  <= port1_word;
          port1_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Bench for dual_port_mem_responder: directed plan steps plus a random phase, both
// INIT_CLEAR settings side by side, checked against a word-array reference model.
module tb_dual_port_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, rst_b;
  logic [AW-1:0] p0_addr, p1_addr;
  logic          p0_re, p1_we, p1_re;
  logic [DW-1:0] p1_wdata;
  logic [SW-1:0] p1_strb;

  logic [DW-1:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic          a_rv0, a_rv1, a_rdy, b_rv0, b_rv1, b_rdy;

  dual_port_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_CLEAR(1'b1)) dut_a (
    .clk(clk), .rst(rst_a),
    .port0_addr(p0_addr), .port0_read_en(p0_re), .port0_rdata(a_rd0), .port0_rvalid(a_rv0),
    .port1_addr(p1_addr), .port1_wdata(p1_wdata), .port1_write_en(p1_we),
    .port1_strobe(p1_strb), .port1_read_en(p1_re), .port1_rdata(a_rd1),
    .port1_rvalid(a_rv1), .ready(a_rdy)
  );

  dual_port_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_CLEAR(1'b0)) dut_b (
    .clk(clk), .rst(rst_b),
    .port0_addr(p0_addr), .port0_read_en(p0_re), .port0_rdata(b_rd0), .port0_rvalid(b_rv0),
    .port1_addr(p1_addr), .port1_wdata(p1_wdata), .port1_write_en(p1_we),
    .port1_strobe(p1_strb), .port1_read_en(p1_re), .port1_rdata(b_rd1),
    .port1_rvalid(b_rv1), .ready(b_rdy)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model, index 0 = sweeping instance, index 1 = no-sweep instance.
  logic [DW-1:0] m_mem [2][DEPTH];
  logic          m_ready [2];
  int            m_sweep [2];
  logic [DW-1:0] m_rd0 [2], m_rd1 [2];
  logic          m_rv0 [2], m_rv1 [2];

  task automatic modelReset(input int d);
    m_ready[d] = 1'b0;
    m_sweep[d] = 0;
    m_rd0[d]   = '0;
    m_rd1[d]   = '0;
    m_rv0[d]   = 1'b0;
    m_rv1[d]   = 1'b0;
  endtask

  task automatic modelEdge(input int d, input logic r);
    logic [DW-1:0] w;
    if (r) begin
      modelReset(d);
      return;
    end
    m_rv0[d] = 1'b0;
    m_rv1[d] = 1'b0;
    if (!m_ready[d]) begin
      if (d == 0) begin
        m_mem[d][m_sweep[d]] = '0;
        m_sweep[d]++;
        if (m_sweep[d] == DEPTH) m_ready[d] = 1'b1;
      end else begin
        m_ready[d] = 1'b1;
      end
    end else begin
      // Apply the store first, then serve reads from the updated array.
      if (p1_we) begin
        w = m_mem[d][p1_addr];
        for (int b = 0; b < SW; b++)
          if (p1_strb[b]) w[8*b +: 8] = p1_wdata[8*b +: 8];
        m_mem[d][p1_addr] = w;
      end
      if (p0_re) begin
        m_rd0[d] = m_mem[d][p0_addr];
        m_rv0[d] = 1'b1;
      end
      if (p1_re) begin
        m_rd1[d] = m_mem[d][p1_addr];
        m_rv1[d] = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    modelEdge(0, rst_a);
    modelEdge(1, rst_b);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input int d, input string tag);
    logic [DW-1:0] rd0, rd1;
    logic          rv0, rv1, rdy;
    if (d == 0) begin
      rd0 = a_rd0; rd1 = a_rd1; rv0 = a_rv0; rv1 = a_rv1; rdy = a_rdy;
    end else begin
      rd0 = b_rd0; rd1 = b_rd1; rv0 = b_rv0; rv1 = b_rv1; rdy = b_rdy;
    end
    checkOutput($sformatf("%s_d%0d_ready", tag, d), 32'(rdy), 32'(m_ready[d]));
    checkOutput($sformatf("%s_d%0d_rv0", tag, d), 32'(rv0), 32'(m_rv0[d]));
    checkOutput($sformatf("%s_d%0d_rv1", tag, d), 32'(rv1), 32'(m_rv1[d]));
    checkOutput($sformatf("%s_d%0d_rd0", tag, d), rd0, m_rd0[d]);
    checkOutput($sformatf("%s_d%0d_rd1", tag, d), rd1, m_rd1[d]);
  endtask

  // Drive one cycle of requests, then settle just after the rising edge.
  task automatic applyStimulus(input logic re0, input logic [AW-1:0] a0, input logic we,
                               input logic [AW-1:0] a1, input logic [DW-1:0] wd,
                               input logic [SW-1:0] st, input logic re1);
    p0_re = re0; p0_addr = a0; p1_we = we; p1_addr = a1;
    p1_wdata = wd; p1_strb = st; p1_re = re1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  int edges;
  logic [DW-1:0] exp4 [4];

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    modelReset(0); modelReset(1);
    idle();
    idle();
    checkOutput("reset_a_ready", 32'(a_rdy), 32'd0);
    checkOutput("reset_a_rdata0", a_rd0, 32'd0);
    checkOutput("reset_b_rvalid1", 32'(b_rv1), 32'd0);
    checkAll(0, "reset");
    checkAll(1, "reset");

    // Power-on sweep; the no-sweep instance must be up after one edge.
    rst_a = 1'b0; rst_b = 1'b0;
    edges = 0;
    do begin
      idle();
      edges++;
      if (edges == 1) checkOutput("b_ready_one_edge", 32'(b_rdy), 32'd1);
      checkAll(0, "sweep0");
    end while (!a_rdy && edges < 40);
    checkOutput("t1_poweron_ready_edges", 32'(edges), 32'd16);

    // Preload every word with all ones so the next sweep is observable.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, AW'(i), 32'hFFFF_FFFF, 4'hF, 1'b0);

    $display("[TB] test 1: init sweep over preloaded storage");
    rst_a = 1'b1; modelReset(0);
    idle();
    checkAll(0, "t1_rst");
    rst_a = 1'b0;
    edges = 0;
    do begin
      if (edges == 4) applyStimulus(1'b0, '0, 1'b1, 4'd2, 32'h1234_5678, 4'hF, 1'b0);
      else idle();
      edges++;
      checkAll(0, "t1_sweep");
    end while (!a_rdy && edges < 40);
    checkOutput("t1_ready_edges", 32'(edges), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, AW'(i), 1'b0, AW'(i), '0, '0, 1'b1);
      checkOutput($sformatf("t1_clear_p0_%0d", i), a_rd0, 32'h0);
      checkOutput($sformatf("t1_clear_p1_%0d", i), a_rd1, 32'h0);
      checkAll(0, "t1_read");
      checkAll(1, "t1_read");
    end

    $display("[TB] test 2: byte-strobe store");
    applyStimulus(1'b0, '0, 1'b1, 4'd3, 32'h1122_3344, 4'b1111, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101, 1'b0);
    checkOutput("t2_rvalid_before", 32'(a_rv1), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 4'd3, '0, '0, 1'b1);
    checkOutput("t2_rdata", a_rd1, 32'h11BB_33DD);
    checkOutput("t2_rvalid_pulse", 32'(a_rv1), 32'd1);
    idle();
    checkOutput("t2_rvalid_drop", 32'(a_rv1), 32'd0);
    checkOutput("t2_rdata_hold", a_rd1, 32'h11BB_33DD);
    checkAll(1, "t2");

    $display("[TB] test 3: write-first collision");
    applyStimulus(1'b1, 4'd5, 1'b1, 4'd5, 32'hDEAD_BEEF, 4'b1100, 1'b1);
    checkOutput("t3_p0_merged", a_rd0, 32'hDEAD_0000);
    checkOutput("t3_p1_merged", a_rd1, 32'hDEAD_0000);
    checkAll(0, "t3");
    checkAll(1, "t3");

    $display("[TB] test 4: concurrent streaming");
    exp4 = '{32'h0, 32'h0, 32'h0, 32'h11BB_33DD};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, AW'(i), 1'b1, AW'(8 + i), DW'((8 + i) * 16), 4'hF, 1'b0);
      checkOutput($sformatf("t4_rvalid_%0d", i), 32'(a_rv0), 32'd1);
      checkOutput($sformatf("t4_rdata_%0d", i), a_rd0, exp4[i]);
      checkAll(1, "t4");
    end
    applyStimulus(1'b1, 4'd9, 1'b0, 4'd9, '0, '0, 1'b1);
    checkOutput("t4_addr9_p0", a_rd0, 32'h90);
    checkOutput("t4_addr9_p1", a_rd1, 32'h90);
    checkOutput("t4_addr9_b", b_rd0, 32'h90);

    $display("[TB] test 5: reset mid-operation");
    p0_re = 1'b1; p0_addr = 4'd3; p1_we = 1'b0; p1_re = 1'b0;
    rst_a = 1'b1; modelReset(0);
    @(posedge clk);
    #1;
    checkOutput("t5_rvalid", 32'(a_rv0), 32'd0);
    checkOutput("t5_rdata", a_rd0, 32'd0);
    checkOutput("t5_ready", 32'(a_rdy), 32'd0);
    checkAll(1, "t5");
    rst_a = 1'b0;
    edges = 0;
    do begin
      idle();
      edges++;
      checkAll(0, "t5_sweep");
    end while (!a_rdy && edges < 40);
    checkOutput("t5_ready_edges", 32'(edges), 32'd16);

    $display("[TB] test 6: no-sweep instance keeps data across reset");
    rst_b = 1'b1; modelReset(1);
    idle();
    checkOutput("t6_ready_in_reset", 32'(b_rdy), 32'd0);
    rst_b = 1'b0;
    applyStimulus(1'b1, 4'd9, 1'b0, 4'd9, '0, '0, 1'b1);
    checkOutput("t6_ready_one_edge", 32'(b_rdy), 32'd1);
    checkOutput("t6_first_edge_dropped", 32'(b_rv0), 32'd0);
    applyStimulus(1'b1, 4'd9, 1'b0, 4'd9, '0, '0, 1'b1);
    checkOutput("t6_survive_p0", b_rd0, 32'h90);
    checkOutput("t6_survive_p1", b_rd1, 32'h90);

    $display("[TB] random phase");
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'($urandom_range(1)), AW'($urandom_range(DEPTH - 1)),
                    1'($urandom_range(1)), AW'($urandom_range(DEPTH - 1)),
                    DW'($urandom), SW'($urandom_range(15)), 1'($urandom_range(1)));
      checkAll(0, "rand");
      checkAll(1, "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dual_port_mem_responder.md
# dual_port_mem_responder

Responder side of the core's dual-port memory interface: services instruction fetches on port 0 (read-only) and loads/stores on port 1 (read/write, byte strobes) with a fixed one-cycle registered read latency. It sits below `top_rv32i_core_dualport` in place of the cache model. After reset it zero-clears its storage with an internal sweep FSM, and it ignores requests until `ready` rises. Both ports use word addresses, with byte offset already dropped by the core.

## Interface
- `DATA_WIDTH`, 32, word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 16, word-address width; depth = 2^ADDR_WIDTH words.
- `INIT_CLEAR`, 1, 1 = zero-fill all words after reset; 0 = skip the sweep.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `port0_addr`  in  ADDR_WIDTH  instruction word address.
- `port0_read_en`  in  1  port 0 read request.
- `port0_rdata`  out  DATA_WIDTH  port 0 registered read data.
- `port0_rvalid`  out  1  one-cycle pulse: `port0_rdata` updated this cycle.
- `port1_addr`  in  ADDR_WIDTH  data word address.
- `port1_wdata`  in  DATA_WIDTH  store data.
- `port1_write_en`  in  1  store request.
- `port1_strobe`  in  DATA_WIDTH/8  byte-lane enables for the store; bit i covers bits [8i+7:8i].
- `port1_read_en`  in  1  load request.
- `port1_rdata`  out  DATA_WIDTH  port 1 registered read data.
- `port1_rvalid`  out  1  one-cycle pulse: `port1_rdata` updated this cycle.
- `ready`  out  1  high once init is complete; requests are accepted only while high.

## Operation
- **States:** INIT and RUN.
- **Reset (async):**
  - State goes to INIT if `INIT_CLEAR`=1, else RUN.
  - `init_addr`=0, `ready`=0.
  - Both `rdata`=0, both `rvalid`=0.
  - Storage contents are not reset.
- **INIT, each edge:**
  - Write 0 to `mem[init_addr]`, then `init_addr`+1.
  - On the edge that writes address 2^ADDR_WIDTH−1, move to RUN and set `ready`=1.
  - All port requests are dropped: no writes, `rvalid` stays 0, `rdata` holds.
- **RUN with INIT_CLEAR=0:** `ready` goes to 1 on the first edge after `rst` falls. Requests on that same edge are dropped.
- **RUN, port 1 write** (`port1_write_en`=1):
  - Only the strobed lanes change: `mem[a]` ← (`old` & ~`mask`) | (`wdata` & `mask`), where `mask` is the strobe expanded to bytes.
  - A strobe of all zeros leaves the word unchanged.
- **RUN, reads** (`readX_en`=1 sampled at edge N):
  - `portX_rdata` ← word at `portX_addr`.
  - `portX_rvalid`=1 for the cycle after edge N.
  - `rdata` holds its value until the next accepted read.
- **Collision handling is write-first on both ports.** If the port 0 read and/or port 1 read address equals the port 1 write address in the same cycle, the returned data is the merged post-write word.
- **Port 1 read and write together:** the same rule applies to the same address, i.e. the merged word is returned.
- **Independence:** the ports have no arbitration and never stall. Both can complete every cycle.
- **Reset mid-INIT or mid-RUN:** reset behaves exactly as the power-on reset above, and the sweep restarts at 0. A read pending at reset produces no `rvalid`.

## Timing
- **Read latency:** exactly 1 cycle, request edge to data/`rvalid`. Throughput is 1 read per port per cycle.
- **Write latency:** the write is visible to any read sampled on the following edge, or on the same edge via write-first.
- **Init duration:**
  - `INIT_CLEAR`=1: `ready` rises exactly 2^ADDR_WIDTH edges after `rst` deasserts.
  - `INIT_CLEAR`=0: 1 edge.
- **Reset values:** `ready`, both `rvalid` are 0; both `rdata` are 0.
- **Register boundaries:** all outputs are driven from registers, with no combinational path from inputs to outputs.

## Test plan
Parameters for the bench: `ADDR_WIDTH`=4, `DATA_WIDTH`=32.

1. **Init sweep.** Assert `rst` with the storage preloaded to 0xFFFFFFFF, then release it.
   - `ready` rises after exactly 16 edges.
   - Reads of addresses 0..15 then return 0x00000000.
   - A `port1_write_en` issued during INIT leaves the word at 0.
2. **Byte-strobe store.** Write 0x11223344 with strobe 1111 to address 3, then write 0xAABBCCDD with strobe 0101 to address 3.
   - A port 1 read of address 3 returns 0x11BB33DD.
   - `port1_rvalid` pulses exactly one cycle after the read edge.
3. **Write-first collision.** Address 5 holds 0; in one cycle, port 1 writes 0xDEADBEEF (strobe 1100) to address 5 while port 0 and port 1 both read address 5.
   - Both `rdata` = 0xDEAD0000 on the next cycle.
4. **Concurrent streaming.** Port 0 reads addresses 0,1,2,3 back-to-back while port 1 writes `addr`×0x10 to addresses 8..11.
   - Four consecutive `port0_rvalid` pulses with the correct data.
   - No stall.
   - Later reads of address 9 return 0x00000090.
5. **Reset mid-operation.** Assert `rst` on the cycle a port 0 read is issued.
   - `port0_rvalid` stays 0.
   - `rdata` = 0.
   - `ready` = 0 and the sweep restarts from 0; `ready` rises 16 edges after release.
6. **INIT_CLEAR=0.**
   - `ready` = 1 one edge after reset release.
   - Previously written data survives the reset.
